updn_count_param: RTL and testbench

//   Parametrised loadable up/down counter; successor to the fixed 4-bit counter.

---
 rtl/updn_count_param.sv | 137 +++++++++++++
 tb/tb_updn_count_param.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updn_count_param.sv
// -----------------------------------------------------------------------------
// updn_count_param
//
// Parametrised loadable up/down counter. The count spans 0..MAX_VAL and either
// wraps or saturates at the limits. On a wrap, a registered one-cycle pulse is
// raised: carry for an up-wrap, borrow for a down-wrap. Cascade stages can use
// these pulses as their count enable.
//
// Parameters
//   WIDTH    counter width in bits (>= 2)
//   MAX_VAL  top count value (< 2**WIDTH); default is the all-ones value
//   SATURATE 0 = wrap at the limits, 1 = hold at the limits
//
// Ports
//   clk      rising-edge clock
//   clr      asynchronous reset, active low; clears qout/carry/borrow/cmp_hit
//   en       count enable
//   ld       synchronous load of d (clamped to MAX_VAL); has priority over en
//   d        load value
//   up_down  1 = count up, 0 = count down
//   qout     current count (registered)
//   tc       terminal count (combinational, not gated by en)
//   carry    one-cycle pulse after an up-wrap (registered)
//   borrow   one-cycle pulse after a down-wrap (registered)
//   cmp_val  compare value                      (CNT_CMP_EN only)
//   cmp_hit  registered match of qout to cmp_val (CNT_CMP_EN only)
//
// Build option
//   `define CNT_CMP_EN adds the cmp_val/cmp_hit ports and the compare register.
// -----------------------------------------------------------------------------
module updn_count_param #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             up_down,
   output logic [WIDTH-1:0] qout,
   output logic             tc,
   output logic             carry,
   output logic             borrow
`ifdef CNT_CMP_EN
   ,
   input  logic [WIDTH-1:0] cmp_val,
   output logic             cmp_hit
`endif
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] cnt_q,    cnt_d;
   logic             carry_q,  carry_d;
   logic             borrow_q, borrow_d;

   // Next count and wrap pulses. Priority: load, then count, then hold.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      cnt_d    = cnt_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;

      if (ld) begin
         // Out-of-range load values are clamped so the count never leaves
         // the 0..MAX_VAL window.
         cnt_d = (d > MAX_Q) ? MAX_Q : d;
      end else if (en) begin
         if (up_down) begin
            // >= rather than == keeps the limit check safe for any state.
            if (cnt_q >= MAX_Q) begin
               if (!SATURATE) begin
                  cnt_d   = '0;
                  carry_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            if (cnt_q == '0) begin
               if (!SATURATE) begin
                  cnt_d    = MAX_Q;
                  borrow_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every flop updates from the
         // pre-edge values and the order of these lines does not matter.
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
      end
   end

   assign qout   = cnt_q;
   assign carry  = carry_q;
   assign borrow = borrow_q;

   // Terminal count looks at the current direction, so reversing up_down
   // moves tc to the other limit within the same cycle.
   assign tc = up_down ? (cnt_q == MAX_Q) : (cnt_q == '0);

`ifdef CNT_CMP_EN
   logic cmp_hit_q, cmp_hit_d;

   // Compare against the next count so the flag lines up with qout in the
   // cycle that value is visible, including after loads and hold edges.
   always_comb begin
      cmp_hit_d = (cnt_d == cmp_val);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cmp_hit_q <= 1'b0;
      end else begin
         cmp_hit_q <= cmp_hit_d;
      end
   end

   assign cmp_hit = cmp_hit_q;
`endif

endmodule

// File: tb/tb_updn_count_param.sv
// -----------------------------------------------------------------------------
// tb_updn_count_param
//
// Directed bench for updn_count_param with WIDTH=4, MAX_VAL=9. Two instances
// share all inputs: dut_w wraps (SATURATE=0), dut_s saturates (SATURATE=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_updn_count_param;

   logic       clk = 1'b0;
   logic       clr;
   logic       en;
   logic       ld;
   logic [3:0] d;
   logic       up_down;

   logic [3:0] q_w, q_s;
   logic       tc_w, tc_s;
   logic       carry_w, carry_s;
   logic       borrow_w, borrow_s;
`ifdef CNT_CMP_EN
   logic [3:0] cmp_val;
   logic       hit_w, hit_s;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   updn_count_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_w (
      .clk(clk), .clr(clr), .en(en), .ld(ld), .d(d), .up_down(up_down),
      .qout(q_w), .tc(tc_w), .carry(carry_w), .borrow(borrow_w)
`ifdef CNT_CMP_EN
      , .cmp_val(cmp_val), .cmp_hit(hit_w)
`endif
   );

   updn_count_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_s (
      .clk(clk), .clr(clr), .en(en), .ld(ld), .d(d), .up_down(up_down),
      .qout(q_s), .tc(tc_s), .carry(carry_s), .borrow(borrow_s)
`ifdef CNT_CMP_EN
      , .cmp_val(cmp_val), .cmp_hit(hit_s)
`endif
   );

   // Advance one rising edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b0; en = 1'b0; ld = 1'b0; d = 4'd0; up_down = 1'b1;
`ifdef CNT_CMP_EN
      cmp_val = 4'd0;
`endif
      step();
      step();
      checks++;
      if (q_w !== 4'd0 || carry_w !== 1'b0 || borrow_w !== 1'b0) begin
         errors++;
         $display("FAIL reset_init: q=%0d carry=%b borrow=%b, required q=0 carry=0 borrow=0",
                  q_w, carry_w, borrow_w);
      end
      clr = 1'b1;
      ld = 1'b1; d = 4'd5;
      step();
      ld = 1'b0; en = 1'b1; up_down = 1'b1;
      step();
      checks++;
      if (q_w !== 4'd6) begin
         errors++;
         $display("FAIL reset_precount: q=%0d, required 6", q_w);
      end
      // Assert clr between edges; the clear must appear before the next edge.
      #3 clr = 1'b0;
      #1;
      checks++;
      if (q_w !== 4'd0 || carry_w !== 1'b0 || borrow_w !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: q=%0d carry=%b borrow=%b, required q=0 carry=0 borrow=0",
                  q_w, carry_w, borrow_w);
      end
`ifdef CNT_CMP_EN
      checks++;
      if (hit_w !== 1'b0) begin
         errors++;
         $display("FAIL reset_cmp_hit: got %b, required 0", hit_w);
      end
`endif
      en = 1'b0;
      step();
      clr = 1'b1;
      step();
      checks++;
      if (q_w !== 4'd0) begin
         errors++;
         $display("FAIL reset_release_hold: q=%0d, required 0", q_w);
      end
      en = 1'b1;
      step();
      checks++;
      if (q_w !== 4'd1) begin
         errors++;
         $display("FAIL reset_resume: q=%0d, required 1", q_w);
      end
   endtask

   task automatic test_up_wrap();
      logic [3:0] exp_q  [3] = '{4'd9, 4'd0, 4'd1};
      logic       exp_c  [3] = '{1'b0, 1'b1, 1'b0};
      logic       exp_tc [3] = '{1'b1, 1'b0, 1'b0};
      logic [3:0] exp_qs [3] = '{4'd9, 4'd9, 4'd9};
      ld = 1'b1; en = 1'b0; d = 4'd8; up_down = 1'b1;
      step();
      checks++;
      if (q_w !== 4'd8 || tc_w !== 1'b0 || carry_w !== 1'b0) begin
         errors++;
         $display("FAIL up_load8: q=%0d tc=%b carry=%b, required q=8 tc=0 carry=0",
                  q_w, tc_w, carry_w);
      end
      ld = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (q_w !== exp_q[i] || carry_w !== exp_c[i] || tc_w !== exp_tc[i] ||
             borrow_w !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap[%0d]: q=%0d carry=%b tc=%b borrow=%b, required q=%0d carry=%b tc=%b borrow=0",
                     i, q_w, carry_w, tc_w, borrow_w, exp_q[i], exp_c[i], exp_tc[i]);
         end
         checks++;
         if (q_s !== exp_qs[i] || carry_s !== 1'b0) begin
            errors++;
            $display("FAIL up_sat[%0d]: q=%0d carry=%b, required q=%0d carry=0",
                     i, q_s, carry_s, exp_qs[i]);
         end
      end
   endtask

   task automatic test_down_wrap();
      logic [3:0] exp_q  [3] = '{4'd0, 4'd9, 4'd8};
      logic       exp_b  [3] = '{1'b0, 1'b1, 1'b0};
      logic       exp_tc [3] = '{1'b1, 1'b0, 1'b0};
      ld = 1'b1; en = 1'b0; d = 4'd1;
      step();
      ld = 1'b0; en = 1'b1; up_down = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (q_w !== exp_q[i] || borrow_w !== exp_b[i] || tc_w !== exp_tc[i] ||
             carry_w !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap[%0d]: q=%0d borrow=%b tc=%b carry=%b, required q=%0d borrow=%b tc=%b carry=0",
                     i, q_w, borrow_w, tc_w, carry_w, exp_q[i], exp_b[i], exp_tc[i]);
         end
      end
   endtask

   task automatic test_saturate();
      logic [3:0] exp_qw_up [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
      ld = 1'b1; en = 1'b0; d = 4'd9; up_down = 1'b1;
      step();
      ld = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (q_s !== 4'd9 || carry_s !== 1'b0 || tc_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_top[%0d]: q=%0d carry=%b tc=%b, required q=9 carry=0 tc=1",
                     i, q_s, carry_s, tc_s);
         end
         checks++;
         if (q_w !== exp_qw_up[i]) begin
            errors++;
            $display("FAIL sat_top_wrapdut[%0d]: q=%0d, required %0d", i, q_w, exp_qw_up[i]);
         end
      end
      ld = 1'b1; en = 1'b0; d = 4'd0;
      step();
      ld = 1'b0; en = 1'b1; up_down = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (q_s !== 4'd0 || borrow_s !== 1'b0 || tc_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_bottom[%0d]: q=%0d borrow=%b tc=%b, required q=0 borrow=0 tc=1",
                     i, q_s, borrow_s, tc_s);
         end
      end
      // Wrapping instance went 0 -> 9 -> 8 over the same two edges.
      checks++;
      if (q_w !== 4'd8) begin
         errors++;
         $display("FAIL sat_bottom_wrapdut: q=%0d, required 8", q_w);
      end
   endtask

   task automatic test_load_clamp();
      // Starts from q_w=8; load with en=1 must win and clamp 15 to 9.
      ld = 1'b1; en = 1'b1; up_down = 1'b1; d = 4'hF;
      step();
      checks++;
      if (q_w !== 4'd9 || carry_w !== 1'b0 || borrow_w !== 1'b0) begin
         errors++;
         $display("FAIL load_clamp: q=%0d carry=%b borrow=%b, required q=9 carry=0 borrow=0",
                  q_w, carry_w, borrow_w);
      end
      // At 9 with en=1 up: a count would wrap, but load keeps it at 9.
      step();
      checks++;
      if (q_w !== 4'd9 || carry_w !== 1'b0) begin
         errors++;
         $display("FAIL load_over_en: q=%0d carry=%b, required q=9 carry=0", q_w, carry_w);
      end
      ld = 1'b0; en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (q_w !== 4'd9 || carry_w !== 1'b0 || borrow_w !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: q=%0d carry=%b borrow=%b, required q=9 carry=0 borrow=0",
                     i, q_w, carry_w, borrow_w);
         end
      end
   endtask

   task automatic test_reversal();
      // q_w=9: tc follows up_down without waiting for an edge.
      up_down = 1'b0;
      #1;
      checks++;
      if (tc_w !== 1'b0) begin
         errors++;
         $display("FAIL rev_tc_down: tc=%b, required 0", tc_w);
      end
      en = 1'b1;
      step();
      checks++;
      if (q_w !== 4'd8) begin
         errors++;
         $display("FAIL rev_down: q=%0d, required 8", q_w);
      end
      up_down = 1'b1;
      step();
      checks++;
      if (q_w !== 4'd9 || tc_w !== 1'b1) begin
         errors++;
         $display("FAIL rev_up: q=%0d tc=%b, required q=9 tc=1", q_w, tc_w);
      end
      en = 1'b0;
   endtask

`ifdef CNT_CMP_EN
   task automatic test_compare();
      logic [3:0] exp_q   [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
      logic       exp_hit [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      cmp_val = 4'd3;
      ld = 1'b1; en = 1'b0; d = 4'd0; up_down = 1'b1;
      step();
      checks++;
      if (q_w !== 4'd0 || hit_w !== 1'b0) begin
         errors++;
         $display("FAIL cmp_start: q=%0d hit=%b, required q=0 hit=0", q_w, hit_w);
      end
      ld = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (q_w !== exp_q[i] || hit_w !== exp_hit[i]) begin
            errors++;
            $display("FAIL cmp_count[%0d]: q=%0d hit=%b, required q=%0d hit=%b",
                     i, q_w, hit_w, exp_q[i], exp_hit[i]);
         end
      end
      ld = 1'b1; en = 1'b0; d = 4'd3;
      step();
      checks++;
      if (q_w !== 4'd3 || hit_w !== 1'b1 || hit_s !== 1'b1) begin
         errors++;
         $display("FAIL cmp_load: q=%0d hit_w=%b hit_s=%b, required q=3 hit=1",
                  q_w, hit_w, hit_s);
      end
      ld = 1'b0;
      step();
      checks++;
      if (hit_w !== 1'b1) begin
         errors++;
         $display("FAIL cmp_hold: hit=%b, required 1", hit_w);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_saturate();
      test_load_clamp();
      test_reversal();
`ifdef CNT_CMP_EN
      test_compare();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past 100000 ns");
      $fatal(1, "timeout");
   end

endmodule
